// File: rtl/clint_axil_slave_pkg.sv
// Shared constants, FSM state encodings and the address decoder for the CLINT AXI4-Lite responder.
package clint_axil_slave_pkg;

  localparam logic [31:0] MTIME_LO_OFF    = 32'd0;
  localparam logic [31:0] MTIME_HI_OFF    = 32'd4;
  localparam logic [31:0] MTIMECMP_LO_OFF = 32'd8;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'd12;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI
  } reg_sel_t;

  // Full 32-bit match against the base; anything else falls through to SEL_NONE.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic        cmp_en);
    logic [31:0] off;
    off = addr - base;
    if (off == MTIME_LO_OFF)                 return SEL_MTIME_LO;
    if (off == MTIME_HI_OFF)                 return SEL_MTIME_HI;
    if (cmp_en && (off == MTIMECMP_LO_OFF))  return SEL_CMP_LO;
    if (cmp_en && (off == MTIMECMP_HI_OFF))  return SEL_CMP_HI;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/clint_axil_slave_mtime_counter.sv
// Free-running 64-bit mtime with a TICK_DIV prescaler; a half-word write replaces
// that half and suppresses the increment in the same cycle.
module clint_mtime_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          tick;

  assign tick = (prescaler == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint_axil_slave.sv
// AXI4-Lite responder exposing the CLINT mtime counter as two 32-bit words.
// Optional macro CLINT_MTIMECMP_EN adds mtimecmp at BASE_ADDR+8/+12 and timer_irq.
module clint_axil_slave
  import clint_axil_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'ha0000048,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready
`ifdef CLINT_MTIMECMP_EN
  ,
  output logic        timer_irq
`endif
);

`ifdef CLINT_MTIMECMP_EN
  localparam logic CMP_EN = 1'b1;
`else
  localparam logic CMP_EN = 1'b0;
`endif

  logic [63:0] mtime;
  logic [31:0] shadow_hi;

  // ---------------- read path ----------------
  r_state_t    r_state, r_next;
  reg_sel_t    rd_sel;
  logic [31:0] rd_val;
  logic        ar_hs;

  assign ar_hs  = arvalid && arready;
  assign rd_sel = decode_addr(araddr, BASE_ADDR, CMP_EN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs)            r_next = R_DATA;
      R_DATA: if (rvalid && rready) r_next = R_IDLE;
      default:                      r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

`ifdef CLINT_MTIMECMP_EN
  logic [63:0] mtimecmp;
`endif

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      SEL_MTIME_LO: rd_val = mtime[31:0];
      SEL_MTIME_HI: rd_val = shadow_hi;
`ifdef CLINT_MTIMECMP_EN
      SEL_CMP_LO:   rd_val = mtimecmp[31:0];
      SEL_CMP_HI:   rd_val = mtimecmp[63:32];
`endif
      default:      rd_val = '0;
    endcase
  end

  // Latching the high word on a low-word read makes a low-then-high pair coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata     <= '0;
      shadow_hi <= '0;
    end else if (ar_hs) begin
      rdata <= rd_val;
      if (rd_sel == SEL_MTIME_LO) shadow_hi <= mtime[63:32];
    end
  end

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  logic        aw_done, w_done, commit;
  logic [31:0] aw_addr_q, w_data_q;
  reg_sel_t    wr_sel;

  assign commit = (w_state == W_IDLE) && aw_done && w_done;
  assign wr_sel = decode_addr(aw_addr_q, BASE_ADDR, CMP_EN);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (commit)            w_next = W_RESP;
      W_RESP: if (bvalid && bready)  w_next = W_IDLE;
      default:                       w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE) && !aw_done;
    wready  = (w_state == W_IDLE) && !w_done;
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (bvalid && bready) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // NOTE: address/data holding registers carry no reset; they are only consumed
  // once aw_done/w_done (which are reset) say they hold a captured value.
  always_ff @(posedge clk) begin
    if (awvalid && awready) aw_addr_q <= awaddr;
    if (wvalid && wready)   w_data_q  <= wdata;
  end

  clint_mtime_counter #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (commit && (wr_sel == SEL_MTIME_LO)),
    .wr_hi (commit && (wr_sel == SEL_MTIME_HI)),
    .wdata (w_data_q),
    .mtime (mtime)
  );

`ifdef CLINT_MTIMECMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      if (commit && (wr_sel == SEL_CMP_LO)) mtimecmp[31:0]  <= w_data_q;
      if (commit && (wr_sel == SEL_CMP_HI)) mtimecmp[63:32] <= w_data_q;
      timer_irq <= (mtime >= mtimecmp);
    end
  end
`endif

endmodule

// File: tb/tb_clint_axil_slave.sv
// Self-checking bench for clint_axil_slave: cycle model + read scoreboard, a vector
// table for word decode, and directed sequences for the multi-cycle corner cases.
module tb_clint_axil_slave;

  localparam logic [31:0] BASE = 32'ha0000048;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
`ifdef CLINT_MTIMECMP_EN
  logic        timer_irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  clint_axil_slave #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
`ifdef CLINT_MTIMECMP_EN
    , .timer_irq(timer_irq)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_awaddr, m_wdata;
  logic        m_rbusy, m_wresp, m_awc, m_wc, m_irq;
  logic [31:0] sb[$];

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off == 32'd0) return m_mtime[31:0];
    if (off == 32'd4) return m_shadow;
`ifdef CLINT_MTIMECMP_EN
    if (off == 32'd8)  return m_cmp[31:0];
    if (off == 32'd12) return m_cmp[63:32];
`endif
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] nxt;
    logic [31:0] off;
    if (rst) begin
      m_mtime <= '0; m_cmp <= '1; m_shadow <= '0; m_irq <= 1'b0;
      m_rbusy <= 1'b0; m_wresp <= 1'b0; m_awc <= 1'b0; m_wc <= 1'b0;
      sb.delete();
    end else begin
      nxt = m_mtime + 64'd1;
      if (!m_wresp && m_awc && m_wc) begin
        off = m_awaddr - BASE;
        if (off == 32'd0)      nxt = {m_mtime[63:32], m_wdata};
        else if (off == 32'd4) nxt = {m_wdata, m_mtime[31:0]};
`ifdef CLINT_MTIMECMP_EN
        else if (off == 32'd8)  m_cmp[31:0]  <= m_wdata;
        else if (off == 32'd12) m_cmp[63:32] <= m_wdata;
`endif
        m_wresp <= 1'b1;
      end else if (m_wresp && bready) begin
        m_wresp <= 1'b0; m_awc <= 1'b0; m_wc <= 1'b0;
      end else if (!m_wresp) begin
        if (awvalid && !m_awc) begin m_awc <= 1'b1; m_awaddr <= awaddr; end
        if (wvalid && !m_wc)   begin m_wc  <= 1'b1; m_wdata  <= wdata;  end
      end
      m_mtime <= nxt;
      m_irq   <= (m_mtime >= m_cmp);
      if (!m_rbusy && arvalid) begin
        sb.push_back(exp_read(araddr));
        m_rbusy <= 1'b1;
        if (araddr == BASE) m_shadow <= m_mtime[63:32];
      end else if (m_rbusy && rready) begin
        m_rbusy <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of handshake outputs and scoreboarded read data.
  always @(negedge clk) begin
    if (mon_en) begin
      check("arready", arready, !m_rbusy);
      check("rvalid",  rvalid,  m_rbusy);
      check("awready", awready, !m_wresp && !m_awc);
      check("wready",  wready,  !m_wresp && !m_wc);
      check("bvalid",  bvalid,  m_wresp);
`ifdef CLINT_MTIMECMP_EN
      check("timer_irq", timer_irq, m_irq);
`endif
      if (rvalid) begin
        if (sb.size() == 0) begin
          timeout_fail("rdata_scoreboard_empty");
        end else begin
          check("rdata", rdata, sb[0]);
          if (rready) void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- drivers (entered #1 after a rising edge) ----------------
  task automatic do_read(input logic [31:0] addr, input int r_delay, output logic [31:0] data);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) timeout_fail("ar_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1'b1);
    check("arready_busy", arready, 1'b0);
    repeat (r_delay) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1'b1);
      check("arready_hold", arready, 1'b0);
    end
    data = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", rvalid, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int w_lead, input int b_delay);
    int n;
    if (w_lead == 0) begin
      awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      wdata = data; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      check("wready_after_w", wready, 1'b0);
      repeat (w_lead - 1) begin @(posedge clk); #1; end
      awaddr = addr; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) timeout_fail("b_wait");
    repeat (b_delay) begin
      check("bvalid_hold", bvalid, 1'b1);
      check("awready_resp", awready, 1'b0);
      check("wready_resp", wready, 1'b0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    check("awready_back", awready, 1'b1);
    check("wready_back", wready, 1'b1);
  endtask

  typedef struct {
    logic [31:0] seed_hi;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] exp_hi;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[5];
    logic [31:0] lo, hi, d;

    vecs[0] = '{32'h0000_0000, BASE + 32'd4,  32'hdead_beef, 32'hdead_beef};
    vecs[1] = '{32'h0000_0007, 32'ha000_0060, 32'h0000_0055, 32'h0000_0007};
    vecs[2] = '{32'h0000_0003, BASE + 32'd8,  32'h0000_0099, 32'h0000_0003};
    vecs[3] = '{32'ha5a5_a5a5, BASE,          32'h0000_0abc, 32'ha5a5_a5a5};
    vecs[4] = '{32'hffff_ffff, BASE + 32'd4,  32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_arready", arready, 1'b1);
    check("reset_rdata", rdata, 32'h0);
    check("reset_bvalid", bvalid, 1'b0);

    // First read: AR handshake on the 12th edge after reset, mtime there is 11.
    repeat (11) @(posedge clk);
    #1;
    do_read(BASE, 2, d);
    check("first_read", d, 32'd11);

    // 64-bit wrap.
    do_write(BASE + 32'd4, 32'hffff_ffff, 0, 0);
    do_write(BASE, 32'hffff_ffff, 0, 0);
    do_read(BASE, 0, lo);
    do_read(BASE + 32'd4, 0, hi);
    check("wrap_lo_small", lo < 32'h10, 1'b1);
    check("wrap_hi_zero", hi, 32'h0);

    // Carry between a low read and the following high read.
    do_write(BASE + 32'd4, 32'h5, 0, 0);
    do_write(BASE, 32'hffff_fff0, 0, 0);
    do_read(BASE, 0, lo);
    check("carry_lo_pre", lo[31:4] == 28'hfff_ffff, 1'b1);
    repeat (20) begin @(posedge clk); #1; end
    do_read(BASE + 32'd4, 0, hi);
    check("carry_hi_shadow", hi, 32'h5);
    do_read(BASE, 0, lo);
    do_read(BASE + 32'd4, 0, hi);
    check("carry_hi_after", hi, 32'h6);

    // W three cycles ahead of AW, response held off for four cycles.
    do_write(BASE, 32'h100, 3, 4);
    do_read(BASE, 0, lo);
    check("wfirst_lo", (lo - 32'h100) < 32'h10, 1'b1);

    // Unmapped address.
    do_read(32'ha000_0060, 0, d);
    check("unmapped_read", d, 32'h0);
    do_write(32'ha000_0060, 32'h1234_5678, 0, 0);
    do_read(BASE, 0, lo);
    do_read(BASE + 32'd4, 0, hi);
    check("unmapped_lo", (lo - 32'h100) < 32'h40, 1'b1);
    check("unmapped_hi", hi, 32'h6);

    // Decode table: seed high word, apply one write, clear low word, read the pair.
    for (int i = 0; i < 5; i++) begin
      do_write(BASE + 32'd4, vecs[i].seed_hi, 0, 0);
      do_write(vecs[i].wr_addr, vecs[i].wr_data, 0, 0);
      do_write(BASE, 32'h0, 0, 0);
      do_read(BASE, 0, lo);
      do_read(BASE + 32'd4, 0, hi);
      check($sformatf("tbl%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("tbl%0d_lo", i), lo < 32'h40, 1'b1);
    end

    // Reset with both responses pending.
    araddr = BASE; arvalid = 1'b1;
    awaddr = BASE + 32'd4; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    check("pend_rvalid", rvalid, 1'b1);
    check("pend_bvalid", bvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_arready", arready, 1'b1);
    rst = 1'b0;
    do_read(BASE, 0, lo);
    check("rst_mtime_lo", lo, 32'h0);
    do_read(BASE + 32'd4, 0, hi);
    check("rst_mtime_hi", hi, 32'h0);

`ifdef CLINT_MTIMECMP_EN
    do_write(BASE + 32'd12, 32'h0, 0, 0);
    do_write(BASE + 32'd8, 32'h5, 0, 0);
    do_write(BASE, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("irq_step%0d", i), timer_irq, (i == 5));
    end
    do_read(BASE + 32'd8, 0, d);
    check("cmp_lo_read", d, 32'h5);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
